// File: rtl/bp_me_wb_mem_responder.sv
// bp_me_wb_mem_responder
//   Wishbone B4 responder backed by a synchronous, word-addressed memory.
//   Supports classic cycles with wait_cycles_p idle cycles before the
//   first ack, and incrementing bursts (cti/bte) with registered feedback.
//
// Ports
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   adr_i      word address (ignored while a burst is in progress)
//   dat_i      write data
//   cyc_i      bus cycle valid
//   stb_i      strobe
//   sel_i      byte enables, one per 8-bit lane of dat_i
//   we_i       write enable
//   cti_i      cycle type: 000 classic, 010 incrementing burst, 111 end
//   bte_i      burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   dat_o      read data, valid while ack_o is high
//   ack_o      normal termination
//   err_o      error termination (address out of range)
module bp_me_wb_mem_responder #(
    parameter int data_width_p  = 64,
    parameter int adr_width_p   = 37,
    parameter int els_p         = 1024,
    parameter int wait_cycles_p = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [adr_width_p-1:0]    adr_i,
    input  logic [data_width_p-1:0]   dat_i,
    input  logic                      cyc_i,
    input  logic                      stb_i,
    input  logic [data_width_p/8-1:0] sel_i,
    input  logic                      we_i,
    input  logic [2:0]                cti_i,
    input  logic [1:0]                bte_i,
    output logic [data_width_p-1:0]   dat_o,
    output logic                      ack_o,
    output logic                      err_o
);

    localparam int SEL_W = data_width_p / 8;
    localparam int IDX_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [3:0] WAIT_C = 4'(wait_cycles_p);
    localparam logic [adr_width_p:0] ELS_A = (adr_width_p + 1)'(els_p);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_BURST
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [3:0]               r_cnt;
    logic [3:0]               w_cnt_nxt;
    logic [adr_width_p-1:0]   r_adr;
    logic [adr_width_p-1:0]   w_adr_nxt;
    logic                     r_ack;
    logic                     r_err;
    logic [data_width_p-1:0]  r_dat;
    logic [data_width_p-1:0]  r_mem [els_p];

    logic                     w_req;
    logic                     w_beat;
    logic [adr_width_p-1:0]   w_beat_adr;
    logic                     w_in_range;
    logic [IDX_W-1:0]         w_idx;
    logic [data_width_p-1:0]  w_bmask;

    // Next burst address: linear increments the whole word address; wrap-N
    // increments only the low log2(N) bits and holds the rest.
    function automatic logic [adr_width_p-1:0] f_next_adr(
        input logic [adr_width_p-1:0] a,
        input logic [1:0]             bte
    );
        logic [adr_width_p-1:0] m;
        case (bte)
            2'b01:   m = adr_width_p'(3);
            2'b10:   m = adr_width_p'(7);
            2'b11:   m = adr_width_p'(15);
            default: m = '0;
        endcase
        if (bte == 2'b00) begin
            return a + adr_width_p'(1);
        end
        return (a & ~m) | ((a + adr_width_p'(1)) & m);
    endfunction

    assign w_req      = cyc_i & stb_i;
    // Inside a burst the predicted address replaces the master's adr_i.
    assign w_beat_adr = (r_state == ST_BURST) ? r_adr : adr_i;
    assign w_in_range = ({1'b0, w_beat_adr} < ELS_A);
    assign w_idx      = w_beat_adr[IDX_W-1:0];

    for (genvar g = 0; g < SEL_W; g++) begin : g_bmask
        assign w_bmask[8*g +: 8] = {8{sel_i[g]}};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_adr_nxt   = r_adr;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Not accepting while the previous termination is still on
                // the bus keeps a master that has not yet dropped stb from
                // re-triggering the same access.
                if (w_req && !r_ack && !r_err) begin
                    if (WAIT_C == 4'd0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = WAIT_C;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (w_req) begin
                    w_beat    = 1'b1;
                    w_adr_nxt = f_next_adr(adr_i, bte_i);
                    if (w_in_range && cti_i == 3'b010) begin
                        w_state_nxt = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                w_state_nxt = ST_IDLE;
                if (w_req) begin
                    w_beat    = 1'b1;
                    w_adr_nxt = f_next_adr(r_adr, bte_i);
                    if (w_in_range && cti_i != 3'b111) begin
                        w_state_nxt = ST_BURST;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_adr   <= w_adr_nxt;
            r_ack   <= w_beat & w_in_range;
            r_err   <= w_beat & ~w_in_range;
            r_dat   <= (w_beat && w_in_range && !we_i) ? r_mem[w_idx] : '0;
        end
    end

    // Memory is not reset; writes are gated by the FSM, which reset
    // forces to IDLE asynchronously, so an aborted cycle never writes.
    always_ff @(posedge clk_i) begin
        if (w_beat && w_in_range && we_i) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (dat_i & w_bmask);
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;

endmodule

// File: tb/tb_bp_me_wb_mem_responder.sv
// Self-checking bench for bp_me_wb_mem_responder: one instance with no wait
// states (u0) and one with three (u3). Inputs are driven 1 ns after the
// rising edge and outputs sampled at the same point.
module tb_bp_me_wb_mem_responder;

    localparam int DW  = 64;
    localparam int AW  = 37;
    localparam int ELS = 1024;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [7:0]    sel;
    logic          we;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          cyc0, stb0, cyc3, stb3;
    logic [DW-1:0] dout0, dout3;
    logic          ack0, err0, ack3, err3;

    typedef struct {
        logic        ack;
        logic        err;
        logic        cd;     // compare dat_o
        logic [63:0] dat;
        int          lat;    // cycles from sampling edge to first response
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [63:0]   d;
        logic [7:0]    sel;
        logic          ack;
        logic          err;
        logic          cd;
        logic [63:0]   dat;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bp_me_wb_mem_responder #(
        .data_width_p (DW),
        .adr_width_p  (AW),
        .els_p        (ELS),
        .wait_cycles_p(0)
    ) u0 (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .adr_i    (adr),
        .dat_i    (wdat),
        .cyc_i    (cyc0),
        .stb_i    (stb0),
        .sel_i    (sel),
        .we_i     (we),
        .cti_i    (cti),
        .bte_i    (bte),
        .dat_o    (dout0),
        .ack_o    (ack0),
        .err_o    (err0)
    );

    bp_me_wb_mem_responder #(
        .data_width_p (DW),
        .adr_width_p  (AW),
        .els_p        (ELS),
        .wait_cycles_p(3)
    ) u3 (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .adr_i    (adr),
        .dat_i    (wdat),
        .cyc_i    (cyc3),
        .stb_i    (stb3),
        .sel_i    (sel),
        .we_i     (we),
        .cti_i    (cti),
        .bte_i    (bte),
        .dat_o    (dout3),
        .ack_o    (ack3),
        .err_o    (err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic f_ack(input int u);
        return (u == 0) ? ack0 : ack3;
    endfunction

    function automatic logic f_err(input int u);
        return (u == 0) ? err0 : err3;
    endfunction

    function automatic logic [63:0] f_dat(input int u);
        return (u == 0) ? dout0 : dout3;
    endfunction

    task automatic set_req(input int u, input logic v);
        if (u == 0) begin
            cyc0 = v;
            stb0 = v;
        end else begin
            cyc3 = v;
            stb3 = v;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic a, input logic e, input logic cd,
                        input logic [63:0] d, input int lat);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.cd  = cd;
        x.dat = d;
        x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic cmp_exp(input int u, input string nm, input exp_t e);
        chk({nm, " ack"}, 64'(f_ack(u)), 64'(e.ack));
        chk({nm, " err"}, 64'(f_err(u)), 64'(e.err));
        if (e.cd) chk({nm, " dat"}, f_dat(u), e.dat);
    endtask

    task automatic wait_resp(input int u, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (f_ack(u) || f_err(u)) seen = 1'b1;
        end
    endtask

    task automatic classic(input int u, input logic w, input logic [AW-1:0] a,
                           input logic [63:0] d, input logic [7:0] s, input string nm);
        int   lat;
        bit   seen;
        exp_t e;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        cti  = 3'b000;
        bte  = 2'b00;
        set_req(u, 1'b1);
        @(posedge clk);
        wait_resp(u, lat, seen);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL %s timeout: no ack/err after %0d cycles", nm, lat);
            end else begin
                chk({nm, " latency"}, 64'(lat), 64'(e.lat));
                cmp_exp(u, nm, e);
            end
        end
        set_req(u, 1'b0);
        @(posedge clk);
        #1;
        chk({nm, " one-cycle term"}, 64'(f_ack(u) | f_err(u)), 64'd0);
    endtask

    // Drives a burst of n intended beats; beat i carries data d0+i and a
    // deliberately wrong adr_i after the first beat. nresp responses are
    // expected on consecutive cycles from the scoreboard.
    task automatic burst(input int u, input logic w, input logic [AW-1:0] a,
                         input logic [1:0] b, input int n, input logic end111,
                         input logic [63:0] d0, input int nresp, input string nm);
        int   lat;
        bit   seen;
        exp_t e;
        we   = w;
        adr  = a;
        bte  = b;
        sel  = 8'hFF;
        wdat = d0;
        cti  = (end111 && n == 1) ? 3'b111 : 3'b010;
        set_req(u, 1'b1);
        @(posedge clk);
        wait_resp(u, lat, seen);
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no first response after %0d cycles", nm, lat);
            sb.delete();
        end else begin
            for (int i = 0; i < nresp; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s: scoreboard empty at beat %0d", nm, i);
                    break;
                end
                e = sb.pop_front();
                if (i == 0) chk({nm, " latency"}, 64'(lat), 64'(e.lat));
                cmp_exp(u, $sformatf("%s beat%0d", nm, i), e);
                wdat = d0 + 64'(i + 1);
                adr  = 37'h1F;
                cti  = (end111 && i + 1 == n - 1) ? 3'b111 : 3'b010;
            end
            // Request still held: a finished burst must not produce a beat.
            @(posedge clk);
            #1;
            chk({nm, " ended"}, 64'(f_ack(u) | f_err(u)), 64'd0);
        end
        set_req(u, 1'b0);
        cti = 3'b000;
        bte = 2'b00;
        @(posedge clk);
        #1;
        chk({nm, " idle"}, 64'(f_ack(u) | f_err(u)), 64'd0);
    endtask

    initial begin
        vec_t tbl[13];
        int   nresp;

        tbl[0]  = '{1'b1, 37'd5,    64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[1]  = '{1'b0, 37'd5,    64'd0,                   8'hFF, 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};
        tbl[2]  = '{1'b1, 37'd9,    64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[3]  = '{1'b1, 37'd9,    64'd0,                   8'h0F, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[4]  = '{1'b0, 37'd9,    64'd0,                   8'hFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
        tbl[5]  = '{1'b1, 37'd9,    64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[6]  = '{1'b0, 37'd9,    64'd0,                   8'hFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
        tbl[7]  = '{1'b0, 37'd1024, 64'd0,                   8'hFF, 1'b0, 1'b1, 1'b1, 64'd0};
        tbl[8]  = '{1'b1, 37'd976,  64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[9]  = '{1'b1, 37'd2000, 64'h5555_5555_5555_5555, 8'hFF, 1'b0, 1'b1, 1'b1, 64'd0};
        tbl[10] = '{1'b0, 37'd976,  64'd0,                   8'hFF, 1'b1, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[11] = '{1'b1, 37'd1023, 64'h00C0_FFEE_00C0_FFEE, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[12] = '{1'b0, 37'd1023, 64'd0,                   8'hFF, 1'b1, 1'b0, 1'b1, 64'h00C0_FFEE_00C0_FFEE};

        rst_n = 1'b0;
        adr   = '0;
        wdat  = '0;
        sel   = '0;
        we    = 1'b0;
        cti   = 3'b000;
        bte   = 2'b00;
        cyc0  = 1'b0;
        stb0  = 1'b0;
        cyc3  = 1'b0;
        stb3  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset ack0", 64'(ack0), 64'd0);
        chk("reset err0", 64'(err0), 64'd0);
        chk("reset dat0", dout0, 64'd0);
        chk("reset ack3", 64'(ack3), 64'd0);
        chk("reset err3", 64'(err3), 64'd0);
        chk("reset dat3", dout3, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Classic cycles, no wait states.
        for (int i = 0; i < 13; i++) begin
            push(tbl[i].ack, tbl[i].err, tbl[i].cd, tbl[i].dat, 1);
            classic(0, tbl[i].we, tbl[i].adr, tbl[i].d, tbl[i].sel, $sformatf("vec%0d", i));
        end

        // Wrap4 from 6: beats land on 6,7,4,5.
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 64'd0, 1);
        burst(0, 1'b1, 37'd6, 2'b01, 4, 1'b1, 64'h6000, 4, "wrap4 wr");
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b1, 64'h6000 + 64'(i), 1);
        burst(0, 1'b0, 37'd6, 2'b01, 4, 1'b1, 64'd0, 4, "wrap4 rd");
        push(1'b1, 1'b0, 1'b1, 64'h6002, 1);
        classic(0, 1'b0, 37'd4, 64'd0, 8'hFF, "wrap4 chk4");
        push(1'b1, 1'b0, 1'b1, 64'h6003, 1);
        classic(0, 1'b0, 37'd5, 64'd0, 8'hFF, "wrap4 chk5");
        push(1'b1, 1'b0, 1'b1, 64'h6000, 1);
        classic(0, 1'b0, 37'd6, 64'd0, 8'hFF, "wrap4 chk6");
        push(1'b1, 1'b0, 1'b1, 64'h6001, 1);
        classic(0, 1'b0, 37'd7, 64'd0, 8'hFF, "wrap4 chk7");

        // Linear from 1020: four in-range beats then err on the fifth.
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 64'd0, 1);
        burst(0, 1'b1, 37'd1020, 2'b00, 4, 1'b1, 64'hC0DE_0000, 4, "lin wr");
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b1, 64'hC0DE_0000 + 64'(i), 1);
        push(1'b0, 1'b1, 1'b1, 64'd0, 1);
        nresp = 5;
        burst(0, 1'b0, 37'd1020, 2'b00, 8, 1'b0, 64'd0, nresp, "lin rd");

        // Three wait states: first response four cycles after sampling.
        push(1'b1, 1'b0, 1'b0, 64'd0, 4);
        classic(3, 1'b1, 37'd5, 64'hDEAD_BEEF_0000_0005, 8'hFF, "w3 wr5");
        push(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0005, 4);
        classic(3, 1'b0, 37'd5, 64'd0, 8'hFF, "w3 rd5");

        // Strobe dropped during WAIT: no termination at all.
        we  = 1'b0;
        adr = 37'd5;
        set_req(3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        set_req(3, 1'b0);
        begin
            int hits;
            hits = 0;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (ack3 || err3) hits++;
            end
            chk("wait drop no term", 64'(hits), 64'd0);
        end
        push(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0005, 4);
        classic(3, 1'b0, 37'd5, 64'd0, 8'hFF, "w3 after drop");

        // Reset during the WAIT of a write to adr 3.
        push(1'b1, 1'b0, 1'b0, 64'd0, 4);
        classic(3, 1'b1, 37'd3, 64'h3333_AAAA_3333_AAAA, 8'hFF, "w3 wr3");
        we   = 1'b1;
        adr  = 37'd3;
        wdat = 64'h0BAD_0BAD_0BAD_0BAD;
        sel  = 8'hFF;
        set_req(3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst ack3", 64'(ack3), 64'd0);
        chk("rst err3", 64'(err3), 64'd0);
        chk("rst dat3", dout3, 64'd0);
        begin
            int hits;
            hits = 0;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (ack3 || err3) hits++;
            end
            chk("rst held no term", 64'(hits), 64'd0);
        end
        set_req(3, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 1'b0, 1'b1, 64'h3333_AAAA_3333_AAAA, 4);
        classic(3, 1'b0, 37'd3, 64'd0, 8'hFF, "post-reset rd3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
